// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame deserializer.
// The frame line idles high, a low start bit opens a frame and a high stop bit closes it.
package serial_frame_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      STOP  = 2'd2,
      BREAK = 2'd3
   } state_t;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int BIT_COUNT_WIDTH    = $clog2(DEFAULT_DATA_WIDTH);

   // Guards against a zero-width counter when only a single data bit is used.
   function automatic int bit_count_width(input int data_width);
      return (data_width > 1) ? $clog2(data_width) : 1;
   endfunction

endpackage

// File: rtl/serial_frame_hold_reg.sv
// Valid/ready holding register for received words, with overrun detection
// and a wrapping count of the words accepted into it.
module serial_frame_hold_reg #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic [DATA_WIDTH-1:0]  load_data,
   input  logic                   ready,
   input  logic                   clear_errors,
   output logic [DATA_WIDTH-1:0]  data,
   output logic                   valid,
   output logic                   overrun,
   output logic [COUNT_WIDTH-1:0] count
);

   logic transfer;
   logic can_load;

   // A word leaving on this edge frees the slot for a word arriving on the same edge.
   assign transfer = valid & ready;
   assign can_load = ~valid | transfer;

   always_ff @(posedge clk) begin
      if (reset) begin
         data    <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
         count   <= '0;
      end else begin
         if (load && can_load) begin
            data  <= load_data;
            valid <= 1'b1;
            count <= count + COUNT_WIDTH'(1);
         end else if (transfer) begin
            valid <= 1'b0;
         end

         // A new overrun outranks a clear requested on the same edge.
         if (load && !can_load) begin
            overrun <= 1'b1;
         end else if (clear_errors) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Frame FSM and shifter: recovers start/data/stop framed words from a one-bit-per-clock
// serial line and hands good words to the holding register.
module serial_frame_deserializer
   import serial_frame_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   Clk_In,
   input  logic                   Reset_In,
   input  logic                   Serial_Data_In,
   input  logic                   Clear_Errors,
   output logic [DATA_WIDTH-1:0]  Data_Out,
   output logic                   Data_Out_Valid,
   input  logic                   Data_Out_Ready,
   output logic                   Frame_Error,
   output logic                   Overrun_Error,
   output logic [COUNT_WIDTH-1:0] Frame_Count,
   output logic                   Busy
);

   localparam int CW = bit_count_width(DATA_WIDTH);

   state_t                state;
   state_t                next_state;
   logic [CW-1:0]         bit_count;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic                  last_bit;
   logic                  shift_en;
   logic                  good_stop;
   logic                  bad_stop;
   logic                  frame_error_q;

   assign last_bit = (bit_count == CW'(DATA_WIDTH - 1));

   always_ff @(posedge Clk_In) begin
      if (Reset_In) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (Serial_Data_In == START_BIT) next_state = DATA;
         DATA:    if (last_bit) next_state = STOP;
         STOP:    next_state = (Serial_Data_In == STOP_BIT) ? IDLE : BREAK;
         BREAK:   if (Serial_Data_In == IDLE_LEVEL) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      shift_en  = (state == DATA);
      good_stop = (state == STOP) && (Serial_Data_In == STOP_BIT);
      bad_stop  = (state == STOP) && (Serial_Data_In != STOP_BIT);
      Busy      = (state != IDLE);
   end

   // Data bits arrive LSB first, so shifting in at the top leaves the first bit at bit 0.
   always_ff @(posedge Clk_In) begin
      if (Reset_In) begin
         bit_count     <= '0;
         shift_reg     <= '0;
         frame_error_q <= 1'b0;
      end else begin
         frame_error_q <= bad_stop;
         if (state == IDLE) begin
            bit_count <= '0;
         end else if (shift_en) begin
            bit_count <= bit_count + CW'(1);
         end
         if (shift_en) begin
            shift_reg <= {Serial_Data_In, shift_reg[DATA_WIDTH-1:1]};
         end
      end
   end

   assign Frame_Error = frame_error_q;

   serial_frame_hold_reg #(
      .DATA_WIDTH  (DATA_WIDTH),
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_hold_reg (
      .clk          (Clk_In),
      .reset        (Reset_In),
      .load         (good_stop),
      .load_data    (shift_reg),
      .ready        (Data_Out_Ready),
      .clear_errors (Clear_Errors),
      .data         (Data_Out),
      .valid        (Data_Out_Valid),
      .overrun      (Overrun_Error),
      .count        (Frame_Count)
   );

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench for serial_frame_deserializer: a table of frames plus hand-written
// sequences for reset, overrun, line break, same-edge handshake and counter wrap.
module tb_serial_frame_deserializer;

   logic        clk;
   logic        reset;
   logic        serial;
   logic        clear;
   logic        ready;
   logic [7:0]  data_out;
   logic        valid;
   logic        frame_err;
   logic        overrun;
   logic [15:0] count;
   logic        busy;
   logic [7:0]  small_data;
   logic        small_valid;
   logic        small_ferr;
   logic        small_overrun;
   logic [3:0]  small_count;
   logic        small_busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0]  data;
      logic        stop;
      int          gap;
      logic        exp_valid;
      logic [7:0]  exp_data;
      logic [15:0] exp_count;
      logic        exp_ferr;
   } vec_t;

   vec_t vecs[7];

   serial_frame_deserializer #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
      .Clk_In         (clk),
      .Reset_In       (reset),
      .Serial_Data_In (serial),
      .Clear_Errors   (clear),
      .Data_Out       (data_out),
      .Data_Out_Valid (valid),
      .Data_Out_Ready (ready),
      .Frame_Error    (frame_err),
      .Overrun_Error  (overrun),
      .Frame_Count    (count),
      .Busy           (busy)
   );

   // Narrow counter copy so the wrap-around is reachable in a short run.
   serial_frame_deserializer #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut_small (
      .Clk_In         (clk),
      .Reset_In       (reset),
      .Serial_Data_In (serial),
      .Clear_Errors   (clear),
      .Data_Out       (small_data),
      .Data_Out_Valid (small_valid),
      .Data_Out_Ready (ready),
      .Frame_Error    (small_ferr),
      .Overrun_Error  (small_overrun),
      .Frame_Count    (small_count),
      .Busy           (small_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic bit_val);
      serial = bit_val;
      tick();
   endtask

   task automatic sendIdle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1);
   endtask

   task automatic sendStartAndData(input logic [7:0] value);
      applyStimulus(1'b0);
      for (int i = 0; i < 8; i++) applyStimulus(value[i]);
   endtask

   task automatic sendFrame(input logic [7:0] value, input logic stop_bit);
      sendStartAndData(value);
      applyStimulus(stop_bit);
   endtask

   task automatic doReset();
      reset  = 1'b1;
      serial = 1'b1;
      repeat (5) tick();
      reset  = 1'b0;
   endtask

   initial begin
      logic expect_drop;
      logic all_busy;
      logic any_ferr;
      logic any_valid;

      reset  = 1'b0;
      serial = 1'b1;
      clear  = 1'b0;
      ready  = 1'b0;

      vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: 1, exp_valid: 1'b1, exp_data: 8'hA5, exp_count: 16'd1, exp_ferr: 1'b0};
      vecs[1] = '{data: 8'h3C, stop: 1'b1, gap: 0, exp_valid: 1'b1, exp_data: 8'h3C, exp_count: 16'd2, exp_ferr: 1'b0};
      vecs[2] = '{data: 8'h5A, stop: 1'b0, gap: 0, exp_valid: 1'b0, exp_data: 8'h3C, exp_count: 16'd2, exp_ferr: 1'b1};
      vecs[3] = '{data: 8'hFF, stop: 1'b1, gap: 1, exp_valid: 1'b1, exp_data: 8'hFF, exp_count: 16'd3, exp_ferr: 1'b0};
      vecs[4] = '{data: 8'h00, stop: 1'b1, gap: 0, exp_valid: 1'b1, exp_data: 8'h00, exp_count: 16'd4, exp_ferr: 1'b0};
      vecs[5] = '{data: 8'h81, stop: 1'b0, gap: 0, exp_valid: 1'b0, exp_data: 8'h00, exp_count: 16'd4, exp_ferr: 1'b1};
      vecs[6] = '{data: 8'h7E, stop: 1'b1, gap: 1, exp_valid: 1'b1, exp_data: 8'h7E, exp_count: 16'd5, exp_ferr: 1'b0};

      // Reset state with the line idle.
      doReset();
      checkOutput("reset data",    data_out,  32'h0);
      checkOutput("reset valid",   valid,     32'h0);
      checkOutput("reset ferr",    frame_err, 32'h0);
      checkOutput("reset overrun", overrun,   32'h0);
      checkOutput("reset count",   count,     32'h0);
      checkOutput("reset busy",    busy,      32'h0);

      // Reset in the middle of a frame abandons it silently.
      ready = 1'b1;
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      checkOutput("midframe busy before reset", busy, 32'h1);
      reset = 1'b1;
      applyStimulus(1'b1);
      reset = 1'b0;
      checkOutput("midframe busy", busy, 32'h0);
      checkOutput("midframe ferr", frame_err, 32'h0);
      checkOutput("midframe valid", valid, 32'h0);
      sendIdle(12);
      checkOutput("midframe no late valid", valid, 32'h0);
      checkOutput("midframe count", count, 32'h0);

      // Table of frames with Ready held high.
      doReset();
      ready = 1'b1;
      expect_drop = 1'b0;
      for (int v = 0; v < 7; v++) begin
         for (int g = 0; g < vecs[v].gap; g++) begin
            applyStimulus(1'b1);
            if (g == 0 && expect_drop) checkOutput($sformatf("vec%0d prior valid drop", v), valid, 32'h0);
         end
         applyStimulus(1'b0);
         if (vecs[v].gap == 0 && expect_drop) checkOutput($sformatf("vec%0d prior valid drop", v), valid, 32'h0);
         for (int i = 0; i < 8; i++) applyStimulus(vecs[v].data[i]);
         checkOutput($sformatf("vec%0d valid before stop", v), valid, 32'h0);
         applyStimulus(vecs[v].stop);
         checkOutput($sformatf("vec%0d valid", v), valid,     {31'h0, vecs[v].exp_valid});
         checkOutput($sformatf("vec%0d data", v),  data_out,  {24'h0, vecs[v].exp_data});
         checkOutput($sformatf("vec%0d count", v), count,     {16'h0, vecs[v].exp_count});
         checkOutput($sformatf("vec%0d ferr", v),  frame_err, {31'h0, vecs[v].exp_ferr});
         checkOutput($sformatf("vec%0d busy", v),  busy,      {31'h0, ~vecs[v].stop});
         expect_drop = vecs[v].exp_valid;
      end
      applyStimulus(1'b1);
      checkOutput("table final valid drop", valid, 32'h0);

      // Overrun with Ready low, then clear, then set-wins-over-clear.
      doReset();
      ready = 1'b0;
      sendIdle(1);
      sendFrame(8'h3C, 1'b1);
      checkOutput("ovr first valid", valid, 32'h1);
      checkOutput("ovr first data", data_out, 32'h3C);
      checkOutput("ovr first flag", overrun, 32'h0);
      sendFrame(8'hFF, 1'b1);
      checkOutput("ovr data held", data_out, 32'h3C);
      checkOutput("ovr flag set", overrun, 32'h1);
      checkOutput("ovr count", count, 32'h1);
      checkOutput("ovr valid held", valid, 32'h1);
      clear = 1'b1;
      applyStimulus(1'b1);
      clear = 1'b0;
      checkOutput("ovr cleared", overrun, 32'h0);
      clear = 1'b1;
      sendFrame(8'h44, 1'b1);
      clear = 1'b0;
      checkOutput("ovr set wins", overrun, 32'h1);
      checkOutput("ovr set wins data", data_out, 32'h3C);

      // Bad stop bit followed by a long break.
      doReset();
      ready = 1'b1;
      sendIdle(1);
      sendFrame(8'h5A, 1'b0);
      checkOutput("break ferr pulse", frame_err, 32'h1);
      checkOutput("break valid", valid, 32'h0);
      checkOutput("break busy at stop", busy, 32'h1);
      applyStimulus(1'b0);
      checkOutput("break ferr one cycle", frame_err, 32'h0);
      all_busy  = busy;
      any_ferr  = frame_err;
      any_valid = valid;
      for (int i = 0; i < 19; i++) begin
         applyStimulus(1'b0);
         all_busy  = all_busy & busy;
         any_ferr  = any_ferr | frame_err;
         any_valid = any_valid | valid;
      end
      checkOutput("break busy throughout", all_busy, 32'h1);
      checkOutput("break no extra ferr", any_ferr, 32'h0);
      checkOutput("break no valid", any_valid, 32'h0);
      applyStimulus(1'b1);
      checkOutput("break back to idle", busy, 32'h0);
      sendIdle(12);
      checkOutput("break no spurious frame", valid, 32'h0);
      checkOutput("break count", count, 32'h0);

      // Ready rises on the very edge that samples the next stop bit.
      doReset();
      ready = 1'b0;
      sendIdle(1);
      sendFrame(8'h11, 1'b1);
      checkOutput("hs first data", data_out, 32'h11);
      sendIdle(1);
      sendStartAndData(8'h22);
      ready = 1'b1;
      applyStimulus(1'b1);
      checkOutput("hs valid kept", valid, 32'h1);
      checkOutput("hs new data", data_out, 32'h22);
      checkOutput("hs no overrun", overrun, 32'h0);
      checkOutput("hs count", count, 32'h2);
      applyStimulus(1'b1);
      checkOutput("hs valid drop", valid, 32'h0);

      // Counter wrap, observed on the 4-bit counter copy.
      doReset();
      ready = 1'b1;
      sendIdle(1);
      for (int k = 1; k <= 17; k++) begin
         sendFrame(8'(k), 1'b1);
         if (k == 15) checkOutput("wrap small at max", small_count, 32'hF);
         if (k == 16) checkOutput("wrap small to zero", small_count, 32'h0);
         if (k == 17) begin
            checkOutput("wrap small after", small_count, 32'h1);
            checkOutput("wrap wide count", count, 32'd17);
            checkOutput("wrap data", small_data, 32'h11);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
